// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control unit: Moore FSM FETCH/DECODE/EXEC/MEM/WB/HALT driving datapath strobes.
// 3-5 cycles per instruction plus one per imem/dmem wait cycle; unsupported encodings latch a sticky halt.
module multicycle_control #(
  parameter int ALUCTRL_W = 3,
  parameter bit BRANCH_EN = 1'b1,
  parameter bit MEMOP_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           instr_opcode,
  input  logic [2:0]           instr_funct3,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 EQ,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 ALUsrc,
  output logic                 PCsrc,
  output logic                 ResultSrc,
  output logic [ALUCTRL_W-1:0] ALUctrl,
  output logic [1:0]           ImmSrc,
  output logic                 illegal
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = '0;
  localparam logic [ALUCTRL_W-1:0] ALU_CMP = ALUCTRL_W'(3'd7);

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] opcode_q, opcode_d;
  logic [2:0] funct3_q, funct3_d;
  logic       illegal_q, illegal_d;

  logic is_addi, is_branch, is_lw, is_sw, is_mem, is_legal, br_taken;

  // Decode works only on the latched instruction; the imem bus is not trusted outside FETCH.
  always_comb begin
    is_addi   = (opcode_q == OP_IMM) && (funct3_q == F3_ADDI);
    is_branch = BRANCH_EN && (opcode_q == OP_BRANCH) &&
                ((funct3_q == F3_BEQ) || (funct3_q == F3_BNE));
    is_lw     = MEMOP_EN && (opcode_q == OP_LOAD)  && (funct3_q == F3_WORD);
    is_sw     = MEMOP_EN && (opcode_q == OP_STORE) && (funct3_q == F3_WORD);
    is_mem    = is_lw || is_sw;
    is_legal  = is_addi || is_branch || is_mem;
    br_taken  = (funct3_q == F3_BNE) ? !EQ : EQ;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FETCH;
      opcode_q  <= '0;
      funct3_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    illegal_d = illegal_q;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    ALUsrc    = 1'b0;
    PCsrc     = 1'b0;
    ResultSrc = 1'b0;
    ALUctrl   = ALU_ADD;
    ImmSrc    = IMM_I;

    unique case (state_q)
      FETCH: begin
        IRWrite = imem_ready;
        PCWrite = imem_ready;
        if (imem_ready) begin
          opcode_d = instr_opcode;
          funct3_d = instr_funct3;
          state_d  = DECODE;
        end
      end

      DECODE: begin
        if (is_legal) begin
          state_d = EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end
      end

      EXEC: begin
        if (is_branch) begin
          ALUctrl = ALU_CMP;
          ImmSrc  = IMM_B;
          PCsrc   = br_taken;
          PCWrite = br_taken;
          state_d = FETCH;
        end else if (is_mem) begin
          ALUsrc  = 1'b1;
          ImmSrc  = is_sw ? IMM_S : IMM_I;
          state_d = MEM;
        end else begin
          ALUsrc  = 1'b1;
          state_d = WB;
        end
      end

      MEM: begin
        // Store strobe is held for the whole access, including the completing cycle.
        MemWrite = is_sw;
        if (dmem_ready) begin
          state_d = is_lw ? WB : FETCH;
        end
      end

      WB: begin
        RegWrite  = 1'b1;
        ResultSrc = is_lw;
        state_d   = FETCH;
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed cycle table, BRANCH_EN=0 build check, randomized instruction stream.
module tb_multicycle_control;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPB = 7'b1100011;
  localparam logic [6:0] OPL = 7'b0000011;
  localparam logic [6:0] OPS = 7'b0100011;
  localparam logic [6:0] OPX = 7'b0110111;

  // {PCWrite,IRWrite,RegWrite,MemWrite,ALUsrc,PCsrc,ResultSrc, ALUctrl[2:0], ImmSrc[1:0], illegal}
  localparam logic [12:0] E0    = 13'b0000000_000_00_0;
  localparam logic [12:0] EFR   = 13'b1100000_000_00_0;
  localparam logic [12:0] EADDI = 13'b0000100_000_00_0;
  localparam logic [12:0] EWBA  = 13'b0010000_000_00_0;
  localparam logic [12:0] EBT   = 13'b1000010_111_10_0;
  localparam logic [12:0] EBN   = 13'b0000000_111_10_0;
  localparam logic [12:0] ELW   = 13'b0000100_000_00_0;
  localparam logic [12:0] ESW   = 13'b0000100_000_01_0;
  localparam logic [12:0] EMSW  = 13'b0001000_000_00_0;
  localparam logic [12:0] EWBL  = 13'b0010001_000_00_0;
  localparam logic [12:0] EILL  = 13'b0000000_000_00_1;

  logic       clk;
  logic       rst;
  logic [6:0] instr_opcode;
  logic [2:0] instr_funct3;
  logic       imem_ready;
  logic       dmem_ready;
  logic       EQ;

  logic       PCWrite, IRWrite, RegWrite, MemWrite, ALUsrc, PCsrc, ResultSrc, illegal;
  logic [2:0] ALUctrl;
  logic [1:0] ImmSrc;

  logic       b_PCWrite, b_IRWrite, b_RegWrite, b_MemWrite, b_ALUsrc, b_PCsrc, b_ResultSrc, b_illegal;
  logic [2:0] b_ALUctrl;
  logic [1:0] b_ImmSrc;

  logic [12:0] out_v, b0_v;
  assign out_v = {PCWrite, IRWrite, RegWrite, MemWrite, ALUsrc, PCsrc, ResultSrc, ALUctrl, ImmSrc, illegal};
  assign b0_v  = {b_PCWrite, b_IRWrite, b_RegWrite, b_MemWrite, b_ALUsrc, b_PCsrc, b_ResultSrc,
                  b_ALUctrl, b_ImmSrc, b_illegal};

  int nvec = 0;
  int nerr = 0;

  multicycle_control #(.ALUCTRL_W(3), .BRANCH_EN(1'b1), .MEMOP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .instr_opcode(instr_opcode), .instr_funct3(instr_funct3),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .EQ(EQ),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ALUsrc(ALUsrc), .PCsrc(PCsrc), .ResultSrc(ResultSrc), .ALUctrl(ALUctrl),
    .ImmSrc(ImmSrc), .illegal(illegal)
  );

  multicycle_control #(.ALUCTRL_W(3), .BRANCH_EN(1'b0), .MEMOP_EN(1'b1)) dut_nobr (
    .clk(clk), .rst(rst), .instr_opcode(instr_opcode), .instr_funct3(instr_funct3),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .EQ(EQ),
    .PCWrite(b_PCWrite), .IRWrite(b_IRWrite), .RegWrite(b_RegWrite), .MemWrite(b_MemWrite),
    .ALUsrc(b_ALUsrc), .PCsrc(b_PCsrc), .ResultSrc(b_ResultSrc), .ALUctrl(b_ALUctrl),
    .ImmSrc(b_ImmSrc), .illegal(b_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  ctl;   // {rst, imem_ready, dmem_ready}
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        eq;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [2:0] ctl, input logic [6:0] op, input logic [2:0] f3,
                     input logic eq, input logic [12:0] exp);
    vec_t v;
    v.ctl = ctl; v.op = op; v.f3 = f3; v.eq = eq; v.exp = exp;
    tbl.push_back(v);
  endtask

  // One clock cycle: drive after the rising edge, compare on the falling edge.
  task automatic step(input logic [2:0] ctl, input logic [6:0] op, input logic [2:0] f3,
                      input logic eq, input logic [12:0] exp, input string nm, input bit nobr);
    logic [12:0] act;
    @(posedge clk);
    #1;
    rst          = ctl[2];
    imem_ready   = ctl[1];
    dmem_ready   = ctl[0];
    instr_opcode = op;
    instr_funct3 = f3;
    EQ           = eq;
    @(negedge clk);
    act = nobr ? b0_v : out_v;
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  function automatic logic [2:0] rf3();
    return 3'($urandom);
  endfunction

  // Reference: the expected trace of one instruction follows directly from its class.
  task automatic rand_instr(input logic [6:0] op, input logic [2:0] f3);
    bit is_addi, is_br, is_lw, is_sw, eq, taken;
    int iw, dw, hw;
    logic [12:0] e_mem;
    is_addi = (op == OPI) && (f3 == 3'd0);
    is_br   = (op == OPB) && ((f3 == 3'd0) || (f3 == 3'd1));
    is_lw   = (op == OPL) && (f3 == 3'd2);
    is_sw   = (op == OPS) && (f3 == 3'd2);
    iw = int'($urandom_range(0, 2));
    for (int i = 0; i < iw; i++) step({1'b1, 1'b0, rb()}, rop(), rf3(), rb(), E0, "r_fetch_wait", 1'b0);
    step({1'b1, 1'b1, rb()}, op, f3, rb(), EFR, "r_fetch", 1'b0);
    step({1'b1, rb(), rb()}, rop(), rf3(), rb(), E0, "r_decode", 1'b0);
    if (!(is_addi || is_br || is_lw || is_sw)) begin
      hw = int'($urandom_range(1, 4));
      for (int i = 0; i < hw; i++) step({1'b1, rb(), rb()}, rop(), rf3(), rb(), EILL, "r_halt", 1'b0);
      step({1'b0, rb(), rb()}, rop(), rf3(), rb(), EILL, "r_halt_rst", 1'b0);
      return;
    end
    eq = rb();
    if (is_br) begin
      taken = (f3 == 3'd0) ? eq : !eq;
      step({1'b1, rb(), rb()}, rop(), rf3(), eq, taken ? EBT : EBN, "r_exec_br", 1'b0);
      return;
    end
    step({1'b1, rb(), rb()}, rop(), rf3(), eq, is_sw ? ESW : EADDI, "r_exec", 1'b0);
    if (is_lw || is_sw) begin
      e_mem = is_sw ? EMSW : E0;
      dw = int'($urandom_range(0, 3));
      for (int i = 0; i < dw; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          step({1'b0, rb(), 1'b0}, rop(), rf3(), rb(), e_mem, "r_mem_rst", 1'b0);
          return;
        end
        step({1'b1, rb(), 1'b0}, rop(), rf3(), rb(), e_mem, "r_mem_wait", 1'b0);
      end
      step({1'b1, rb(), 1'b1}, rop(), rf3(), rb(), e_mem, "r_mem", 1'b0);
      if (is_sw) return;
    end
    step({1'b1, rb(), rb()}, rop(), rf3(), rb(), is_lw ? EWBL : EWBA, "r_wb", 1'b0);
  endtask

  initial begin
    rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    instr_opcode = '0; instr_funct3 = '0; EQ = 1'b0;

    add(3'b000, OPI, 3'd0, 1'b0, E0);
    // addi: RegWrite on cycle 4 only
    add(3'b110, OPI, 3'd0, 1'b0, EFR);  add(3'b100, OPX, 3'd7, 1'b0, E0);
    add(3'b100, OPX, 3'd7, 1'b0, EADDI); add(3'b100, OPX, 3'd7, 1'b0, EWBA);
    // bne EQ=0 taken, EQ=1 not taken; beq both ways
    add(3'b111, OPB, 3'd1, 1'b0, EFR);  add(3'b101, OPI, 3'd0, 1'b0, E0);  add(3'b101, OPI, 3'd0, 1'b0, EBT);
    add(3'b110, OPB, 3'd1, 1'b1, EFR);  add(3'b100, OPI, 3'd0, 1'b1, E0);  add(3'b100, OPI, 3'd0, 1'b1, EBN);
    add(3'b110, OPB, 3'd0, 1'b1, EFR);  add(3'b100, OPI, 3'd0, 1'b1, E0);  add(3'b100, OPI, 3'd0, 1'b1, EBT);
    add(3'b110, OPB, 3'd0, 1'b0, EFR);  add(3'b100, OPI, 3'd0, 1'b0, E0);  add(3'b100, OPI, 3'd0, 1'b0, EBN);
    // lw with three dmem wait cycles: 8 cycles total
    add(3'b110, OPL, 3'd2, 1'b0, EFR);  add(3'b100, OPS, 3'd2, 1'b0, E0);  add(3'b100, OPS, 3'd2, 1'b0, ELW);
    add(3'b100, OPS, 3'd2, 1'b0, E0);   add(3'b110, OPS, 3'd2, 1'b0, E0);  add(3'b100, OPS, 3'd2, 1'b0, E0);
    add(3'b101, OPS, 3'd2, 1'b0, E0);   add(3'b100, OPS, 3'd2, 1'b0, EWBL);
    // sw with one imem wait and one dmem wait
    add(3'b100, OPI, 3'd0, 1'b0, E0);   add(3'b110, OPS, 3'd2, 1'b0, EFR); add(3'b100, OPL, 3'd2, 1'b0, E0);
    add(3'b100, OPL, 3'd2, 1'b0, ESW);  add(3'b100, OPL, 3'd2, 1'b0, EMSW); add(3'b101, OPL, 3'd2, 1'b0, EMSW);
    // unsupported opcode: sticky HALT for 10 cycles, cleared by one reset cycle
    add(3'b110, OPX, 3'd0, 1'b0, EFR);  add(3'b111, OPI, 3'd0, 1'b1, E0);
    for (int i = 0; i < 10; i++) add(3'b111, OPI, 3'd0, 1'b1, EILL);
    add(3'b011, OPI, 3'd0, 1'b1, EILL); add(3'b100, OPI, 3'd0, 1'b0, E0);
    // addi opcode with wrong funct3 is also illegal
    add(3'b110, OPI, 3'd1, 1'b0, EFR);  add(3'b100, OPI, 3'd0, 1'b0, E0);  add(3'b100, OPI, 3'd0, 1'b0, EILL);
    add(3'b000, OPI, 3'd0, 1'b0, EILL); add(3'b100, OPI, 3'd0, 1'b0, E0);
    // sw stalled in MEM, reset drops MemWrite and returns to FETCH without RegWrite
    add(3'b110, OPS, 3'd2, 1'b0, EFR);  add(3'b100, OPI, 3'd0, 1'b0, E0);  add(3'b100, OPI, 3'd0, 1'b0, ESW);
    add(3'b100, OPI, 3'd0, 1'b0, EMSW); add(3'b000, OPI, 3'd0, 1'b0, EMSW);
    add(3'b100, OPI, 3'd0, 1'b0, E0);   add(3'b100, OPI, 3'd0, 1'b0, E0);

    @(posedge clk);
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].ctl, tbl[i].op, tbl[i].f3, tbl[i].eq, tbl[i].exp, $sformatf("tbl[%0d]", i), 1'b0);

    // BRANCH_EN=0 build: beq halts, no PCWrite after FETCH
    step(3'b000, OPI, 3'd0, 1'b0, E0, "nobr_rst", 1'b1);
    step(3'b110, OPB, 3'd0, 1'b1, EFR, "nobr_fetch", 1'b1);
    step(3'b110, OPB, 3'd0, 1'b1, E0, "nobr_decode", 1'b1);
    for (int i = 0; i < 6; i++) step(3'b111, OPB, 3'd0, 1'b1, EILL, "nobr_halt", 1'b1);
    step(3'b000, OPI, 3'd0, 1'b0, EILL, "nobr_halt_rst", 1'b1);

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 11))
        0, 1:    rand_instr(OPI, 3'd0);
        2:       rand_instr(OPB, 3'd0);
        3:       rand_instr(OPB, 3'd1);
        4, 5:    rand_instr(OPL, 3'd2);
        6, 7:    rand_instr(OPS, 3'd2);
        8:       rand_instr(rop(), rf3());
        9:       rand_instr(OPI, rf3());
        10:      rand_instr(OPB, rf3());
        default: rand_instr(rb() ? OPL : OPS, rf3());
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001: Parameter ALUCTRL_W, default 3, width of ALUctrl; SHALL be >= 3.
REQ-002: Parameter BRANCH_EN, default 1; 0 treats opcode 1100011 as illegal.
REQ-003: Parameter MEMOP_EN, default 1; 0 treats opcodes 0000011/0100011 as illegal.
REQ-004: One clock; reset is synchronous and active-low.
REQ-005: clk  input  1  sole clock, all state updates on rising edge.
REQ-006: rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-007: instr_opcode  input  7  opcode from instruction memory, valid while imem_ready=1.
REQ-008: instr_funct3  input  3  funct3 from instruction memory, valid while imem_ready=1.
REQ-009: imem_ready  input  1  instruction fetch complete this cycle.
REQ-010: dmem_ready  input  1  data access complete this cycle.
REQ-011: EQ  input  1  ALU equality flag, valid during EXEC.
REQ-012: PCWrite, IRWrite, RegWrite, MemWrite, ALUsrc, PCsrc, ResultSrc  output  1 each  datapath strobes/selects.
REQ-013: ALUctrl  output  ALUCTRL_W  ALU op: 0 = add, 7 = compare; upper bits zero.
REQ-014: ImmSrc  output  2  00 I-type, 01 S-type, 10 B-type.
REQ-015: illegal  output  1  sticky flag, unsupported opcode/funct3 decoded.

Function
REQ-016: SHALL be a Moore FSM, states FETCH, DECODE, EXEC, MEM, WB, HALT; all outputs decoded from current state plus latched opcode/funct3 (and EQ in EXEC for PCsrc/PCWrite).
REQ-017: FETCH: IRWrite=imem_ready, PCWrite=imem_ready; opcode/funct3 registered when imem_ready=1; -> DECODE on imem_ready=1, else stay.
REQ-018: DECODE: all strobes 0; supported opcode -> EXEC; otherwise illegal<=1, -> HALT.
REQ-019: Supported: 0010011 with funct3=000 (addi); 1100011 with funct3 000 (beq) or 001 (bne); 0000011 funct3=010 (lw); 0100011 funct3=010 (sw); anything else illegal.
REQ-020: EXEC addi: ALUctrl=0, ALUsrc=1, ImmSrc=00 -> WB.
REQ-021: EXEC branch: ALUctrl=7, ALUsrc=0, ImmSrc=10; taken = EQ for beq, !EQ for bne; PCsrc=taken, PCWrite=taken -> FETCH.
REQ-022: EXEC lw/sw: ALUctrl=0, ALUsrc=1, ImmSrc=00 (lw) / 01 (sw) -> MEM.
REQ-023: MEM: MemWrite=1 for sw while waiting; stay until dmem_ready=1; then lw -> WB, sw -> FETCH.
REQ-024: WB: RegWrite=1 for exactly one cycle; ResultSrc=1 for lw, 0 for addi -> FETCH.
REQ-025: Minimum latency with ready inputs held 1: addi 4, branch 3, lw 5, sw 4 cycles, FETCH to FETCH.
REQ-026: Each wait cycle on imem_ready/dmem_ready extends latency by exactly one cycle; no strobe except MemWrite (sw) asserted while waiting.
REQ-027: RegWrite, PCWrite, IRWrite SHALL each assert at most once per instruction.
REQ-028: HALT: all strobes 0, illegal=1, state held until reset.
REQ-029: Outputs not listed for a state SHALL be 0.

Reset
REQ-030: rst=0 at a clock edge -> state FETCH, illegal=0, latched opcode/funct3=0, regardless of current state, including mid-MEM wait or HALT.
REQ-031: During and on the cycle after reset, all strobes (PCWrite, IRWrite, RegWrite, MemWrite) SHALL be 0 except as set by FETCH with imem_ready.

Verification
REQ-032: addi (0010011/000), ready=1 -> RegWrite=1 on cycle 4 only, ALUsrc=1, ALUctrl=0, back in FETCH cycle 5.
REQ-033: bne (1100011/001) with EQ=0 -> cycle 3 PCsrc=1, PCWrite=1; same with EQ=1 -> PCsrc=0, PCWrite=0.
REQ-034: lw with dmem_ready low 3 cycles -> MEM held 4 cycles, then WB RegWrite=1, ResultSrc=1; total 8 cycles.
REQ-035: opcode 0110111 -> illegal=1 after DECODE, HALT holds with all strobes 0 for 10 cycles; rst=0 one cycle -> FETCH, illegal=0.
REQ-036: sw stalled in MEM, rst=0 asserted -> MemWrite drops next cycle, state FETCH, no RegWrite.
REQ-037: BRANCH_EN=0 build, beq opcode -> illegal=1, HALT, PCWrite never asserted after FETCH.
